// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, tolerates imem wait states,
// and parks a completed fetch in a buffer while the hazard unit stalls the pipe.
module if_stage #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]       NOP_INSTR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pc_en,
    input  logic              IF_ID_en,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ready,
    input  logic [31:0]       imem_rdata,
    output logic [ADDR_W-1:0] IF_ID_pc_plus4,
    output logic [31:0]       IF_ID_instr,
    output logic              IF_ID_valid,
    output logic              fetch_stall
);

    typedef enum logic [1:0] {StFetch, StHold, StDrain} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] drain_addr_q, drain_addr_d;
    logic [31:0]       buf_q, buf_d;
    logic [ADDR_W-1:0] id_pc4_q, id_pc4_d;
    logic [31:0]       id_instr_q, id_instr_d;
    logic              id_valid_q, id_valid_d;

    logic              advance;
    logic              redirect;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_plus4;

    assign advance  = pc_en & IF_ID_en;
    assign redirect = IF_ID_en & (jump | branch_taken);
    assign target   = jump ? jump_target : branch_target;
    assign pc_plus4 = pc_q + ADDR_W'(4);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        buf_d        = buf_q;
        id_pc4_d     = id_pc4_q;
        id_instr_d   = id_instr_q;
        id_valid_d   = id_valid_q;

        unique case (state_q)
            StFetch: begin
                if (imem_ready && advance) begin
                    id_pc4_d   = pc_plus4;
                    id_instr_d = imem_rdata;
                    id_valid_d = 1'b1;
                    pc_d       = pc_plus4;
                end else if (imem_ready) begin
                    buf_d   = imem_rdata;
                    state_d = StHold;
                end else if (IF_ID_en) begin
                    id_pc4_d   = '0;
                    id_instr_d = NOP_INSTR;
                    id_valid_d = 1'b0;
                end
            end
            StHold: begin
                if (advance) begin
                    id_pc4_d   = pc_plus4;
                    id_instr_d = buf_q;
                    id_valid_d = 1'b1;
                    pc_d       = pc_plus4;
                    state_d    = StFetch;
                end
            end
            StDrain: begin
                if (imem_ready) state_d = StFetch;
                if (IF_ID_en) begin
                    id_pc4_d   = '0;
                    id_instr_d = NOP_INSTR;
                    id_valid_d = 1'b0;
                end
            end
            default: state_d = StFetch;
        endcase

        // An outstanding request can't be cancelled, so a redirect during a wait must drain it.
        if (redirect) begin
            pc_d       = target;
            id_pc4_d   = '0;
            id_instr_d = NOP_INSTR;
            id_valid_d = 1'b0;
            if (state_q == StFetch && !imem_ready) begin
                drain_addr_d = pc_q;
                state_d      = StDrain;
            end else if (state_q == StDrain) begin
                state_d = StDrain;
            end else begin
                state_d = StFetch;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StFetch;
            pc_q         <= RESET_PC;
            drain_addr_q <= '0;
            buf_q        <= '0;
            id_pc4_q     <= '0;
            id_instr_q   <= NOP_INSTR;
            id_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            buf_q        <= buf_d;
            id_pc4_q     <= id_pc4_d;
            id_instr_q   <= id_instr_d;
            id_valid_q   <= id_valid_d;
        end
    end

    assign imem_req       = rst_n & (state_q != StHold);
    assign imem_addr      = (state_q == StDrain) ? drain_addr_q : pc_q;
    assign fetch_stall    = ((state_q == StFetch) & ~imem_ready) | (state_q == StDrain);
    assign IF_ID_pc_plus4 = id_pc4_q;
    assign IF_ID_instr    = id_instr_q;
    assign IF_ID_valid    = id_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a behavioural imem answers every address, expected IF/ID contents
// are queued as each cycle is driven and checked after the clock edge.
module tb_if_stage;

    localparam logic [31:0] Nop = 32'hFFFF_0000;

    logic        clk;
    logic        rst_n;
    logic        pc_en;
    logic        IF_ID_en;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] IF_ID_pc_plus4;
    logic [31:0] IF_ID_instr;
    logic        IF_ID_valid;
    logic        fetch_stall;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc4;
        logic [31:0] instr;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    if_stage #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(Nop)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_en         (pc_en),
        .IF_ID_en      (IF_ID_en),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .IF_ID_pc_plus4(IF_ID_pc_plus4),
        .IF_ID_instr   (IF_ID_instr),
        .IF_ID_valid   (IF_ID_valid),
        .fetch_stall   (fetch_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0x0 -> 0x20080001, 0x4 -> 0x20090002, 0x8 -> 0x200A0003, ...
    function automatic logic [31:0] mem(input logic [31:0] a);
        return 32'h2008_0001 + (a >> 2) * 32'h0001_0001;
    endfunction

    assign imem_rdata = mem(imem_addr);

    function automatic exp_t ent(input logic v, input logic [31:0] pc4, input logic [31:0] ins);
        ent.valid = v;
        ent.pc4   = pc4;
        ent.instr = ins;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one cycle (called at posedge+1), check combinational outputs, then the IF/ID result.
    task automatic step(input string tag, input logic pe, input logic ie, input logic rdy,
                        input logic br, input logic [31:0] bt, input logic jp,
                        input logic [31:0] jt, input logic e_req, input logic chk_addr,
                        input logic [31:0] e_addr, input logic e_stall, input exp_t e);
        exp_t got;
        exp_t want;
        pc_en         = pe;
        IF_ID_en      = ie;
        imem_ready    = rdy;
        branch_taken  = br;
        branch_target = bt;
        jump          = jp;
        jump_target   = jt;
        sb_q.push_back(e);
        #1;
        chk({tag, ".req"}, {31'd0, imem_req}, {31'd0, e_req});
        if (chk_addr) chk({tag, ".addr"}, imem_addr, e_addr);
        chk({tag, ".stall"}, {31'd0, fetch_stall}, {31'd0, e_stall});
        @(posedge clk);
        #1;
        want = sb_q.pop_front();
        got  = ent(IF_ID_valid, IF_ID_pc_plus4, IF_ID_instr);
        chk({tag, ".valid"}, {31'd0, got.valid}, {31'd0, want.valid});
        chk({tag, ".pc4"}, got.pc4, want.pc4);
        chk({tag, ".instr"}, got.instr, want.instr);
    endtask

    initial begin
        exp_t bub;
        bub           = ent(1'b0, 32'h0, Nop);
        rst_n         = 1'b0;
        pc_en         = 1'b1;
        IF_ID_en      = 1'b1;
        imem_ready    = 1'b1;
        branch_taken  = 1'b0;
        branch_target = '0;
        jump          = 1'b0;
        jump_target   = '0;

        @(posedge clk);
        #1;
        chk("rst.req", {31'd0, imem_req}, 32'd0);
        chk("rst.valid", {31'd0, IF_ID_valid}, 32'd0);
        chk("rst.instr", IF_ID_instr, Nop);
        chk("rst.pc4", IF_ID_pc_plus4, 32'h0);
        rst_n = 1'b1;

        // Zero-wait streaming
        step("s0", 1, 1, 1, 0, 0, 0, 0, 1, 1, 32'h00, 0, ent(1, 32'h04, mem(32'h00)));
        step("s1", 1, 1, 1, 0, 0, 0, 0, 1, 1, 32'h04, 0, ent(1, 32'h08, mem(32'h04)));
        step("s2", 1, 1, 1, 0, 0, 0, 0, 1, 1, 32'h08, 0, ent(1, 32'h0C, mem(32'h08)));
        // Hazard stall: word at 0xC parked, released exactly once
        step("hz0", 0, 0, 1, 0, 0, 0, 0, 1, 1, 32'h0C, 0, ent(1, 32'h0C, mem(32'h08)));
        step("hz1", 0, 0, 1, 0, 0, 0, 0, 0, 0, 32'h00, 0, ent(1, 32'h0C, mem(32'h08)));
        step("hz2", 1, 1, 1, 0, 0, 0, 0, 0, 0, 32'h00, 0, ent(1, 32'h10, mem(32'h0C)));
        // Memory wait at 0x10
        step("mw0", 1, 1, 0, 0, 0, 0, 0, 1, 1, 32'h10, 1, bub);
        step("mw1", 1, 1, 0, 0, 0, 0, 0, 1, 1, 32'h10, 1, bub);
        step("mw2", 1, 1, 0, 0, 0, 0, 0, 1, 1, 32'h10, 1, bub);
        step("mw3", 1, 1, 1, 0, 0, 0, 0, 1, 1, 32'h10, 0, ent(1, 32'h14, mem(32'h10)));
        step("f14", 1, 1, 1, 0, 0, 0, 0, 1, 1, 32'h14, 0, ent(1, 32'h18, mem(32'h14)));
        step("f18", 1, 1, 1, 0, 0, 0, 0, 1, 1, 32'h18, 0, ent(1, 32'h1C, mem(32'h18)));
        step("f1c", 1, 1, 1, 0, 0, 0, 0, 1, 1, 32'h1C, 0, ent(1, 32'h20, mem(32'h1C)));
        // Branch taken while the 0x20 fetch is waiting
        step("bd0", 1, 1, 0, 1, 32'h100, 0, 0, 1, 1, 32'h20, 1, bub);
        step("bd1", 1, 1, 0, 0, 0, 0, 0, 1, 1, 32'h20, 1, bub);
        step("bd2", 1, 1, 1, 0, 0, 0, 0, 1, 1, 32'h20, 1, bub);
        step("bd3", 1, 1, 1, 0, 0, 0, 0, 1, 1, 32'h100, 0, ent(1, 32'h104, mem(32'h100)));
        // Jump and branch together: jump wins
        step("jb0", 1, 1, 1, 1, 32'h80, 1, 32'h40, 1, 1, 32'h104, 0, bub);
        step("jb1", 1, 1, 1, 0, 0, 0, 0, 1, 1, 32'h40, 0, ent(1, 32'h44, mem(32'h40)));
        // Branch with IF_ID_en=0 is ignored
        step("bi0", 1, 0, 1, 1, 32'h80, 0, 0, 1, 1, 32'h44, 0, ent(1, 32'h44, mem(32'h40)));
        step("bi1", 1, 1, 1, 0, 0, 0, 0, 0, 0, 32'h00, 0, ent(1, 32'h48, mem(32'h44)));
        step("bi2", 1, 1, 1, 0, 0, 0, 0, 1, 1, 32'h48, 0, ent(1, 32'h4C, mem(32'h48)));
        // Enter HOLD, then assert reset between clock edges
        step("ar0", 0, 0, 1, 0, 0, 0, 0, 1, 1, 32'h4C, 0, ent(1, 32'h4C, mem(32'h48)));
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar.req", {31'd0, imem_req}, 32'd0);
        chk("ar.valid", {31'd0, IF_ID_valid}, 32'd0);
        chk("ar.instr", IF_ID_instr, Nop);
        chk("ar.pc4", IF_ID_pc_plus4, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step("rf0", 1, 1, 1, 0, 0, 0, 0, 1, 1, 32'h00, 0, ent(1, 32'h04, mem(32'h00)));
        step("rf1", 1, 1, 1, 0, 0, 0, 0, 1, 1, 32'h04, 0, ent(1, 32'h08, mem(32'h04)));

        chk("sb.empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC register and the IF/ID pipeline register.
- Issues requests to instruction memory and tolerates memory wait states.
- Consumes pc_en/IF_ID_en stall controls from the hazard unit and branch/jump redirects from ID; feeds the ID stage.

Parameters:
ADDR_W, 32, PC and memory address width
RESET_PC, 32'h0000_0000, PC value after reset
NOP_INSTR, 32'h0000_0000, instruction word loaded into IF/ID on a bubble or flush

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
pc_en  in  1  hazard-unit PC write enable (0 = stall)
IF_ID_en  in  1  hazard-unit IF/ID write enable (0 = stall)
branch_taken  in  1  ID-stage branch resolved taken
branch_target  in  ADDR_W  branch destination
jump  in  1  ID-stage jump
jump_target  in  ADDR_W  jump destination
imem_req  out  1  fetch request valid
imem_addr  out  ADDR_W  fetch address
imem_ready  in  1  imem_rdata valid this cycle, completes the request
imem_rdata  in  32  fetched instruction
IF_ID_pc_plus4  out  ADDR_W  registered PC+4 of the instruction in ID
IF_ID_instr  out  32  registered instruction
IF_ID_valid  out  1  1 = real instruction, 0 = bubble
fetch_stall  out  1  fetch waiting on memory (status)

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=FETCH, drain_addr=0, buf=0.
  - IF_ID_instr=NOP_INSTR, IF_ID_pc_plus4=0, IF_ID_valid=0.
  - imem_req forced 0 while rst_n=0.
  - The first request is issued in the first cycle after rst_n rises.
- Definitions:
  - advance = pc_en & IF_ID_en.
  - redirect = IF_ID_en & (jump | branch_taken).
  - target = jump ? jump_target : branch_target. Jump wins if both are set.
- All PC arithmetic is modulo 2^ADDR_W, so PC+4 wraps from 0xFFFF_FFFC to 0.
- States:
  - FETCH:
    - Outputs: imem_req=1, imem_addr=pc.
    - imem_ready & advance: IF_ID <= {pc+4, imem_rdata, 1}; pc <= pc+4.
    - imem_ready & !advance: buf <= imem_rdata; go to HOLD. IF_ID and pc hold.
    - !imem_ready: pc holds. If IF_ID_en=1, IF_ID <= bubble {0, NOP_INSTR, 0}; else IF_ID holds.
  - HOLD:
    - Outputs: imem_req=0. The instruction is already captured in buf; no re-fetch.
    - advance: IF_ID <= {pc+4, buf, 1}; pc <= pc+4; go to FETCH.
    - Otherwise all registers hold.
  - DRAIN:
    - Outputs: imem_req=1, imem_addr=drain_addr, which stays stable until completion.
    - The response is discarded.
    - imem_ready: go to FETCH. pc already holds the redirect target.
    - If IF_ID_en=1, IF_ID <= bubble.
- Redirect overrides all state rules above in the same cycle:
  - pc <= target; IF_ID <= bubble.
  - Any buf content or same-cycle imem_rdata is discarded.
  - FETCH with !imem_ready: drain_addr <= pc; go to DRAIN.
  - FETCH with imem_ready, or HOLD: go to FETCH.
  - DRAIN: stay in DRAIN with drain_addr unchanged; pc takes the newest target.
- Redirect is ignored when IF_ID_en=0: the ID instruction is stalled and its branch decision is not final.
- pc_en=1 with IF_ID_en=0 is treated as a stall; the PC never advances without IF/ID.
- fetch_stall = (FETCH & !imem_ready) | DRAIN. It is 0 in HOLD.
- Latency: with zero-wait memory and no stalls, one instruction per cycle. The instruction at pc appears on IF_ID outputs the cycle after imem_ready.
- All outputs except imem_req, imem_addr and fetch_stall are registered. Those three are combinational from state, pc, drain_addr and imem_ready.

Test Plan:
- Reset release, imem_ready=1, memory returns 0x20080001, 0x20090002, 0x200A0003 for 0x0, 0x4, 0x8 → imem_addr 0,4,8 on successive cycles; IF_ID_pc_plus4 4,8,0xC; IF_ID_valid=1 from cycle 2.
- Hazard stall: pc_en=IF_ID_en=0 for 2 cycles with ready=1 → state HOLD, imem_req=0, IF_ID unchanged. On release, buffered word enters IF_ID once; no duplicate, no skip, pc advances by exactly 4.
- Memory wait: imem_ready=0 for 3 cycles at pc=0x10 → fetch_stall=1, imem_addr stable 0x10, IF_ID_valid=0 bubbles. On ready, IF_ID_pc_plus4=0x14.
- Branch during wait: at pc=0x20 with ready=0, branch_taken=1, target=0x100 → DRAIN, imem_addr stays 0x20 until ready, stale data dropped. Next request is at 0x100; IF_ID_valid=0 throughout.
- Jump+branch same cycle (jump_target=0x40, branch_target=0x80), and branch with IF_ID_en=0 → pc=0x40 in the first case; pc unchanged in the second.
- Async reset asserted mid-HOLD → outputs reset immediately without a clock edge; refetch starts at RESET_PC.
